// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the memory address from the fetch PC, captures the
// combinational read data into a small queue and hands instructions to the decoder over a
// valid/ready handshake. Supports PC redirect and stops fetching after a HALT opcode.
module fetch_unit #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter logic [3:0]  HALT_OP  = 4'b0011
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] mem_addr_o,
    input  logic [7:0] mem_dout_i,
    input  logic       mem_grant_i,
    input  logic       redirect_i,
    input  logic [7:0] redirect_pc_i,
    output logic       instr_valid_o,
    output logic [7:0] instr_o,
    output logic [7:0] instr_pc_o,
    input  logic       instr_ready_i,
    output logic       halted_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {StFetch, StHalted} state_e;

    state_e              state_q, state_d;
    logic [7:0]          fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;
    logic [7:0]          instr_mem_q [DEPTH];
    logic [7:0]          pc_mem_q    [DEPTH];

    logic full;
    logic push;
    logic pop;

    assign full          = (count_q == CntW'(DEPTH));
    assign instr_valid_o = (count_q != '0);
    assign pop           = instr_valid_o & instr_ready_i;
    // Pushing into a full queue is allowed when the head leaves in the same cycle.
    assign push          = (state_q == StFetch) & mem_grant_i & ~redirect_i & (~full | pop);

    assign mem_addr_o = fetch_pc_q;
    assign instr_o    = instr_mem_q[rd_ptr_q];
    assign instr_pc_o = pc_mem_q[rd_ptr_q];
    assign halted_o   = (state_q == StHalted);

    // Next-state logic: redirect overrides both push and pop and flushes the queue.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_i) begin
            state_d    = StFetch;
            fetch_pc_d = redirect_pc_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 8'd1;
                wr_ptr_d   = wr_ptr_q + PtrW'(1);
                // The HALT word itself is enqueued; only later fetches stop.
                if (mem_dout_i[7:4] == HALT_OP) begin
                    state_d = StHalted;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StFetch;
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are only meaningful under count_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= mem_dout_i;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected {instr, pc} pairs, a monitor pops
// and compares on every credited handshake; direct checks cover reset, stalls and redirects.
module tb_fetch_unit;

    logic       clk;
    logic       rst;
    logic [7:0] mem_addr;
    logic [7:0] mem_dout;
    logic       mem_grant;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       instr_valid;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_ready;
    logic       halted;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    int          checks   = 0;
    int          failures = 0;

    fetch_unit #(
        .DEPTH    (2),
        .RESET_PC (8'h00),
        .HALT_OP  (4'b0011)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_addr_o    (mem_addr),
        .mem_dout_i    (mem_dout),
        .mem_grant_i   (mem_grant),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_ready_i (instr_ready),
        .halted_o      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational memory model.
    assign mem_dout = mem[mem_addr];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] i, input logic [7:0] p);
        exp_q.push_back({i, p});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every credited handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && instr_valid === 1'b1 && instr_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_instr: got %h@%h expected none", instr, instr_pc);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({instr, instr_pc} !== e) begin
                    failures++;
                    $display("FAIL instr_stream: got %h@%h expected %h@%h",
                             instr, instr_pc, e[15:8], e[7:0]);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h21; mem[8'h01] = 8'h25; mem[8'h02] = 8'h41; mem[8'h03] = 8'h30;
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'h3C;
        mem[8'h40] = 8'hF0;
        mem[8'h80] = 8'h55; mem[8'h81] = 8'h66; mem[8'h82] = 8'h3F;
        mem[8'hFF] = 8'h12;
        rst = 1'b1; mem_grant = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b1;

        // 1: straight-line fetch to HALT
        cyc(2);
        chk("reset_valid", {7'd0, instr_valid}, 8'd0);
        chk("reset_halted", {7'd0, halted}, 8'd0);
        chk("reset_addr", mem_addr, 8'h00);
        push_exp(8'h21, 8'h00); push_exp(8'h25, 8'h01);
        push_exp(8'h41, 8'h02); push_exp(8'h30, 8'h03);
        rst = 1'b0;
        cyc(8);
        chk("t1_halted", {7'd0, halted}, 8'd1);
        chk("t1_addr", mem_addr, 8'h04);
        chk("t1_valid", {7'd0, instr_valid}, 8'd0);
        chk("t1_drained", 8'(exp_q.size()), 8'd0);

        // 2: decoder stall fills the queue
        instr_ready = 1'b0; rst = 1'b1; exp_q.delete();
        cyc(1);
        rst = 1'b0;
        push_exp(8'h21, 8'h00); push_exp(8'h25, 8'h01);
        push_exp(8'h41, 8'h02); push_exp(8'h30, 8'h03);
        cyc(5);
        chk("t2_addr_stall", mem_addr, 8'h02);
        chk("t2_valid", {7'd0, instr_valid}, 8'd1);
        chk("t2_head_instr", instr, 8'h21);
        chk("t2_head_pc", instr_pc, 8'h00);
        chk("t2_not_halted", {7'd0, halted}, 8'd0);
        instr_ready = 1'b1;
        cyc(6);
        chk("t2_drained", 8'(exp_q.size()), 8'd0);
        chk("t2_halted", {7'd0, halted}, 8'd1);

        // 3: grant toggling
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        push_exp(8'h21, 8'h00); push_exp(8'h25, 8'h01);
        push_exp(8'h41, 8'h02); push_exp(8'h30, 8'h03);
        begin
            logic [7:0] exp_addr [4];
            exp_addr[0] = 8'h00; exp_addr[1] = 8'h01; exp_addr[2] = 8'h01; exp_addr[3] = 8'h02;
            for (int i = 0; i < 4; i++) begin
                mem_grant = (i % 2 == 0);
                chk("t3_addr", mem_addr, exp_addr[i]);
                cyc(1);
            end
        end
        chk("t3_addr_held", mem_addr, 8'h02);
        mem_grant = 1'b1;
        cyc(6);
        chk("t3_drained", 8'(exp_q.size()), 8'd0);
        chk("t3_addr_end", mem_addr, 8'h04);

        // 4: redirect with a full queue and ready high
        rst = 1'b1; instr_ready = 1'b0;
        cyc(1);
        rst = 1'b0;
        push_exp(8'h21, 8'h00); push_exp(8'h25, 8'h01);
        cyc(2);
        chk("t4_full_valid", {7'd0, instr_valid}, 8'd1);
        chk("t4_full_addr", mem_addr, 8'h02);
        redirect = 1'b1; redirect_pc = 8'h80; instr_ready = 1'b1;
        exp_q.delete();
        push_exp(8'h55, 8'h80); push_exp(8'h66, 8'h81); push_exp(8'h3F, 8'h82);
        cyc(1);
        redirect = 1'b0;
        chk("t4_flush_valid", {7'd0, instr_valid}, 8'd0);
        chk("t4_redir_addr", mem_addr, 8'h80);
        chk("t4_not_halted", {7'd0, halted}, 8'd0);
        cyc(6);
        chk("t4_drained", 8'(exp_q.size()), 8'd0);
        chk("t4_halted", {7'd0, halted}, 8'd1);
        chk("t4_addr_end", mem_addr, 8'h83);

        // 5: leave HALTED through back-to-back redirects; last one wins
        redirect = 1'b1; redirect_pc = 8'h40;
        cyc(1);
        redirect_pc = 8'h10;
        cyc(1);
        redirect = 1'b0;
        chk("t5_unhalted", {7'd0, halted}, 8'd0);
        chk("t5_valid", {7'd0, instr_valid}, 8'd0);
        chk("t5_addr", mem_addr, 8'h10);
        push_exp(8'hA1, 8'h10); push_exp(8'hB2, 8'h11); push_exp(8'h3C, 8'h12);
        cyc(6);
        chk("t5_drained", 8'(exp_q.size()), 8'd0);
        chk("t5_halted", {7'd0, halted}, 8'd1);
        chk("t5_addr_end", mem_addr, 8'h13);

        // 6: PC wrap, then reset with a valid head
        mem[8'h00] = 8'h13;
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'hFF;
        cyc(1);
        redirect = 1'b0;
        push_exp(8'h12, 8'hFF); push_exp(8'h13, 8'h00);
        cyc(2);
        chk("t6_wrap_addr", mem_addr, 8'h01);
        chk("t6_head_instr", instr, 8'h12);
        chk("t6_head_pc", instr_pc, 8'hFF);
        instr_ready = 1'b1;
        push_exp(8'h25, 8'h01);
        cyc(1);
        instr_ready = 1'b0;
        chk("t6_valid", {7'd0, instr_valid}, 8'd1);
        chk("t6_head2_instr", instr, 8'h13);
        chk("t6_head2_pc", instr_pc, 8'h00);
        rst = 1'b1;
        cyc(1);
        exp_q.delete();
        chk("t6_rst_valid", {7'd0, instr_valid}, 8'd0);
        chk("t6_rst_addr", mem_addr, 8'h00);
        chk("t6_rst_halted", {7'd0, halted}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
